demux1t2_reg: RTL and testbench

DEMUX1T2_REG -- requirements
Module: demux1t2_reg

---
 rtl/demux1t2_reg.sv | 85 ++++++++
 tb/tb_demux1t2_reg.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1t2_reg.sv
// One-to-two valid/ready demultiplexer with a single holding register per
// output channel and per-channel delivered-transfer counters.
module demux1t2_reg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sel,
  output logic [DW-1:0] out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [DW-1:0] out2_data,
  output logic          out2_valid,
  input  logic          out2_ready,
  output logic [7:0]    cnt1,
  output logic [7:0]    cnt2
);

  logic [DW-1:0] r_data1;
  logic [DW-1:0] r_data2;
  logic          r_valid1;
  logic          r_valid2;
  logic [7:0]    r_cnt1;
  logic [7:0]    r_cnt2;

  logic w_ready1;
  logic w_ready2;
  logic w_load1;
  logic w_load2;
  logic w_drain1;
  logic w_drain2;

  // A channel can take a word when empty or when its current word leaves this edge.
  assign w_ready1 = ~r_valid1 | out1_ready;
  assign w_ready2 = ~r_valid2 | out2_ready;
  assign in_ready = sel ? w_ready2 : w_ready1;

  assign w_load1  = in_valid & w_ready1 & ~sel;
  assign w_load2  = in_valid & w_ready2 &  sel;
  assign w_drain1 = r_valid1 & out1_ready;
  assign w_drain2 = r_valid2 & out2_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data1  <= '0;
      r_valid1 <= 1'b0;
      r_cnt1   <= '0;
    end else begin
      if (w_load1) begin
        r_data1  <= in_data;
        r_valid1 <= 1'b1;
      end else if (w_drain1) begin
        r_valid1 <= 1'b0;
      end
      if (w_drain1) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data2  <= '0;
      r_valid2 <= 1'b0;
      r_cnt2   <= '0;
    end else begin
      if (w_load2) begin
        r_data2  <= in_data;
        r_valid2 <= 1'b1;
      end else if (w_drain2) begin
        r_valid2 <= 1'b0;
      end
      if (w_drain2) r_cnt2 <= r_cnt2 + 8'd1;
    end
  end

  assign out1_data  = r_data1;
  assign out1_valid = r_valid1;
  assign out2_data  = r_data2;
  assign out2_valid = r_valid2;
  assign cnt1       = r_cnt1;
  assign cnt2       = r_cnt2;

endmodule

// File: tb/tb_demux1t2_reg.sv
// Self-checking bench for demux1t2_reg: scoreboard queues per channel plus
// directed scenario tasks.
module tb_demux1t2_reg;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          sel;
  logic [DW-1:0] out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out2_data;
  logic          out2_valid;
  logic          out2_ready;
  logic [7:0]    cnt1;
  logic [7:0]    cnt2;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  logic [DW-1:0] del1[$];
  logic [DW-1:0] del2[$];
  logic [7:0]    m_cnt1;
  logic [7:0]    m_cnt2;

  demux1t2_reg #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge rst) begin
    q1.delete();
    q2.delete();
    m_cnt1 = '0;
    m_cnt2 = '0;
  end

  // Golden model: inputs are stable at the falling edge, so it predicts the
  // transfers of the coming rising edge and checks the current outputs.
  always @(negedge clk) begin
    logic exp_ir;
    logic go1, go2;
    if (!rst) begin
      exp_ir = sel ? (q2.size() == 0 || out2_ready) : (q1.size() == 0 || out1_ready);
      checks++;
      if (in_ready !== exp_ir) begin
        errors++;
        $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ir);
      end
      checks++;
      if (out1_valid !== (q1.size() != 0)) begin
        errors++;
        $display("FAIL mon_out1_valid t=%0t got=%b exp=%b", $time, out1_valid, q1.size() != 0);
      end
      checks++;
      if (out2_valid !== (q2.size() != 0)) begin
        errors++;
        $display("FAIL mon_out2_valid t=%0t got=%b exp=%b", $time, out2_valid, q2.size() != 0);
      end
      if (q1.size() != 0) begin
        checks++;
        if (out1_data !== q1[0]) begin
          errors++;
          $display("FAIL mon_out1_data t=%0t got=%h exp=%h", $time, out1_data, q1[0]);
        end
      end
      if (q2.size() != 0) begin
        checks++;
        if (out2_data !== q2[0]) begin
          errors++;
          $display("FAIL mon_out2_data t=%0t got=%h exp=%h", $time, out2_data, q2[0]);
        end
      end
      checks++;
      if (cnt1 !== m_cnt1 || cnt2 !== m_cnt2) begin
        errors++;
        $display("FAIL mon_cnt t=%0t got=%0d/%0d exp=%0d/%0d", $time, cnt1, cnt2, m_cnt1, m_cnt2);
      end
      go1 = (q1.size() != 0) && out1_ready;
      go2 = (q2.size() != 0) && out2_ready;
      if (go1) begin
        del1.push_back(q1.pop_front());
        m_cnt1 = m_cnt1 + 8'd1;
      end
      if (go2) begin
        del2.push_back(q2.pop_front());
        m_cnt2 = m_cnt2 + 8'd1;
      end
      if (in_valid && exp_ir) begin
        if (sel) q2.push_back(in_data);
        else     q1.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; sel = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    del1.delete();
    del2.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; sel = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    #2;
    checks++;
    if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || out1_data !== '0 || out2_data !== '0) begin
      errors++;
      $display("FAIL reset_regs got v=%b%b d=%h/%h exp v=00 d=0/0", out1_valid, out2_valid, out1_data, out2_data);
    end
    checks++;
    if (cnt1 !== 8'd0 || cnt2 !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt1, cnt2);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_sel0 got=%b exp=1", in_ready);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_sel1 got=%b exp=1", in_ready);
    end
    tick();
    rst = 1'b0;
    sel = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single_route();
    do_reset();
    sel = 1'b0; in_data = 4'hA; in_valid = 1'b1; out1_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 4'hA || out2_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_route got v1=%b d1=%h v2=%b exp v1=1 d1=a v2=0", out1_valid, out1_data, out2_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_in_ready_sel0 got=%b exp=0", in_ready);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_in_ready_sel1 got=%b exp=1", in_ready);
    end
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    checks++;
    if (out1_valid !== 1'b0 || cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL single_drain got v1=%b cnt1=%0d exp v1=0 cnt1=1", out1_valid, cnt1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    sel = 1'b0; in_data = 4'h3; in_valid = 1'b1; out1_ready = 1'b0;
    tick();
    in_data = 4'h7;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out1_data !== 4'h3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got d=%h rdy=%b exp d=3 rdy=0", i, out1_data, in_ready);
      end
      tick();
    end
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 4'h7 || cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL backpressure_swap got v=%b d=%h cnt1=%0d exp v=1 d=7 cnt1=1", out1_valid, out1_data, cnt1);
    end
    checks++;
    if (del1.size() != 1 || (del1.size() == 1 && del1[0] !== 4'h3)) begin
      errors++;
      $display("FAIL backpressure_delivered got n=%0d exp n=1 word=3", del1.size());
    end
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
  endtask

  task automatic test_sel_change();
    do_reset();
    sel = 1'b0; in_data = 4'h1; in_valid = 1'b1;
    tick();
    in_data = 4'h4;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out2_valid !== 1'b0) begin
      errors++;
      $display("FAIL selchg_pending got rdy=%b v2=%b exp rdy=0 v2=0", in_ready, out2_valid);
    end
    sel = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 4'h4 || out1_data !== 4'h1) begin
      errors++;
      $display("FAIL selchg_route got v2=%b d2=%h d1=%h exp v2=1 d2=4 d1=1", out2_valid, out2_data, out1_data);
    end
    out1_ready = 1'b1; out2_ready = 1'b1;
    tick();
    out1_ready = 1'b0; out2_ready = 1'b0;
    checks++;
    if (cnt1 !== 8'd1 || cnt2 !== 8'd1 || out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
      errors++;
      $display("FAIL dual_drain got cnt=%0d/%0d v=%b%b exp cnt=1/1 v=00", cnt1, cnt2, out1_valid, out2_valid);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = DW'(i);
      sel = i[0];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (del1.size() != 8 || del2.size() != 8 || cnt1 !== 8'd8 || cnt2 !== 8'd8) begin
      errors++;
      $display("FAIL alt_counts got n=%0d/%0d cnt=%0d/%0d exp 8/8 8/8", del1.size(), del2.size(), cnt1, cnt2);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (del1[k] !== DW'(2 * k) || del2[k] !== DW'(2 * k + 1)) begin
          errors++;
          $display("FAIL alt_order k=%0d got=%h/%h exp=%h/%h", k, del1[k], del2[k], DW'(2 * k), DW'(2 * k + 1));
        end
      end
    end
    out1_ready = 1'b0; out2_ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out2_ready = 1'b1;
    sel = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (cnt2 !== 8'd0 || cnt1 !== 8'd0 || del2.size() != 256) begin
      errors++;
      $display("FAIL counter_wrap got cnt2=%0d cnt1=%0d n=%0d exp 0 0 256", cnt2, cnt1, del2.size());
    end
    out2_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out1_ready = 1'b1; out2_ready = 1'b1;
    sel = 1'b0; in_data = 4'h5; in_valid = 1'b1;
    tick();
    sel = 1'b1; in_data = 4'h6;
    tick();
    in_valid = 1'b0;
    tick();
    out1_ready = 1'b0; out2_ready = 1'b0;
    sel = 1'b0; in_data = 4'h9; in_valid = 1'b1;
    tick();
    sel = 1'b1; in_data = 4'hC;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out2_valid !== 1'b1 || cnt1 !== 8'd1 || cnt2 !== 8'd1) begin
      errors++;
      $display("FAIL async_pre got v=%b%b cnt=%0d/%0d exp v=11 cnt=1/1", out1_valid, out2_valid, cnt1, cnt2);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || cnt1 !== 8'd0 || cnt2 !== 8'd0 ||
        out1_data !== '0 || out2_data !== '0) begin
      errors++;
      $display("FAIL async_clear t=%0t got v=%b%b cnt=%0d/%0d d=%h/%h exp all 0", $time,
               out1_valid, out2_valid, cnt1, cnt2, out1_data, out2_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_in_ready got=%b exp=1", in_ready);
    end
    sel = 1'b0; in_data = 4'hF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b0 || out1_data !== '0) begin
      errors++;
      $display("FAIL async_held got v1=%b d1=%h exp v1=0 d1=0", out1_valid, out1_data);
    end
    rst = 1'b0;
    sel = 1'b1; in_data = 4'h2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 4'h2) begin
      errors++;
      $display("FAIL async_resume got v2=%b d2=%h exp v2=1 d2=2", out2_valid, out2_data);
    end
    out2_ready = 1'b1;
    tick();
    out2_ready = 1'b0;
  endtask

  task automatic test_sweep();
    logic accepted;
    do_reset();
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 2; s++) begin
        in_data = DW'(d);
        sel = s[0];
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 64 && !accepted; n++) begin
          out1_ready = 1'($urandom_range(0, 1));
          out2_ready = 1'($urandom_range(0, 1));
          #1;
          accepted = in_ready;
          tick();
        end
        if (!accepted) begin
          errors++;
          $display("FAIL sweep_timeout t=%0t d=%0d s=%0d", $time, d, s);
        end
      end
    end
    in_valid = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    repeat (4) tick();
    out1_ready = 1'b0; out2_ready = 1'b0;
    checks++;
    if (del1.size() != 16 || del2.size() != 16) begin
      errors++;
      $display("FAIL sweep_count t=%0t got=%0d/%0d exp=16/16", $time, del1.size(), del2.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (del1[k] !== DW'(k) || del2[k] !== DW'(k)) begin
          errors++;
          $display("FAIL sweep_word t=%0t k=%0d got=%h/%h exp=%h", $time, k, del1[k], del2[k], DW'(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_backpressure();
    test_sel_change();
    test_alternating();
    test_counter_wrap();
    test_async_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
